// File: rtl/alu_operand_stack.sv
// rtl/alu_operand_stack.sv - WebAssembly operand stack feeding a 3-cycle non-pipelined ALU issue sequence
//
// Purpose: holds the value stack in a register array, accepts constant pushes
// from decode, pops 1-3 operands per ALU op, presents them to the ALU for one
// cycle, captures the result and pushes it back.
//
// Optional feature macro: OPSTACK_DISCARD_EN adds the op_discard input; a
// discarded op still pulses done but its result is not pushed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push_valid/push_ready    decode push handshake, push_data is the value
//   op_valid/op_ready        ALU op handshake, op_ctrl code, op_nargs pop count
//   op_discard               (OPSTACK_DISCARD_EN only) drop the result
//   alu_A/alu_B/alu_C        registered operands (A = top of stack)
//   alu_ctrl                 registered ALU control
//   alu_result               combinational ALU result, sampled at end of EXEC
//   done/done_result         one-cycle completion pulse and captured result
//   sp, tos                  stack depth and top-of-stack value (0 when empty)
//   err_op                   sticky illegal-op flag, cleared only by rst

module alu_operand_stack #(
    parameter int DEPTH    = 16,
    parameter int ST_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [ST_WIDTH-1:0]        push_data,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [4:0]                 op_ctrl,
    input  logic [1:0]                 op_nargs,
`ifdef OPSTACK_DISCARD_EN
    input  logic                       op_discard,
`endif
    output logic [ST_WIDTH-1:0]        alu_A,
    output logic [ST_WIDTH-1:0]        alu_B,
    output logic [ST_WIDTH-1:0]        alu_C,
    output logic [4:0]                 alu_ctrl,
    input  logic [31:0]                alu_result,
    output logic                       done,
    output logic [31:0]                done_result,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic [ST_WIDTH-1:0]        tos,
    output logic                       err_op
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    state_t              state_q;
    logic [SPW-1:0]      sp_q;
    logic [ST_WIDTH-1:0] stack_q [DEPTH];
    logic [ST_WIDTH-1:0] alu_a_q, alu_b_q, alu_c_q;
    logic [4:0]          alu_ctrl_q;
    logic [31:0]         done_result_q;
    logic                done_q;
    logic                err_q;
    logic                discard_q;

    logic                discard_w;
    logic                push_fire;
    logic                op_fire;
    logic                op_legal;
    logic [AW-1:0]       idx1, idx2, idx3, wr_idx;
    logic                wr_en;
    logic [ST_WIDTH-1:0] wr_data;
    logic [ST_WIDTH-1:0] alu_a_d, alu_b_d, alu_c_d;

`ifdef OPSTACK_DISCARD_EN
    assign discard_w = op_discard;
`else
    assign discard_w = 1'b0;
`endif

    assign push_ready = (state_q == S_IDLE) && (sp_q != SPW'(DEPTH));
    assign op_ready   = (state_q == S_IDLE) && !push_valid;
    assign push_fire  = push_valid && push_ready;
    assign op_fire    = op_valid && op_ready;
    assign op_legal   = (op_nargs != 2'd0) && (SPW'(op_nargs) <= sp_q);

    // Indices below sp wrap when the stack is shallow; they are only used
    // when the request is legal, so the wrapped reads are never latched.
    assign idx1   = AW'(sp_q - SPW'(1));
    assign idx2   = AW'(sp_q - SPW'(2));
    assign idx3   = AW'(sp_q - SPW'(3));
    assign wr_idx = AW'(sp_q);

    // Operands beyond op_nargs are presented as 0.
    always_comb begin
        alu_a_d = '0;
        alu_b_d = '0;
        alu_c_d = '0;
        if (op_nargs >= 2'd1) alu_a_d = stack_q[idx1];
        if (op_nargs >= 2'd2) alu_b_d = stack_q[idx2];
        if (op_nargs == 2'd3) alu_c_d = stack_q[idx3];
    end

    // Single write port: decode pushes in IDLE, ALU result in PUSH.
    // In PUSH there is always room since the op popped at least one entry.
    assign wr_en   = push_fire || ((state_q == S_PUSH) && !discard_q);
    assign wr_data = (state_q == S_PUSH) ? ST_WIDTH'(done_result_q) : push_data;

    // Stack contents are deliberately not reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sp_q          <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_c_q       <= '0;
            alu_ctrl_q    <= '0;
            done_result_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (push_fire) begin
                        sp_q <= sp_q + SPW'(1);
                    end else if (op_fire) begin
                        if (!op_legal) begin
                            // Illegal request is consumed with no other side effect.
                            err_q <= 1'b1;
                        end else begin
                            alu_a_q    <= alu_a_d;
                            alu_b_q    <= alu_b_d;
                            alu_c_q    <= alu_c_d;
                            alu_ctrl_q <= op_ctrl;
                            discard_q  <= discard_w;
                            sp_q       <= sp_q - SPW'(op_nargs);
                            state_q    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    done_result_q <= alu_result;
                    done_q        <= 1'b1;
                    state_q       <= S_PUSH;
                end
                S_PUSH: begin
                    done_q <= 1'b0;
                    if (!discard_q) begin
                        sp_q <= sp_q + SPW'(1);
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_A       = alu_a_q;
    assign alu_B       = alu_b_q;
    assign alu_C       = alu_c_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign done        = done_q;
    assign done_result = done_result_q;
    assign sp          = sp_q;
    assign tos         = (sp_q == '0) ? '0 : stack_q[idx1];
    assign err_op      = err_q;

endmodule

// File: tb/tb_alu_operand_stack.sv
// tb/tb_alu_operand_stack.sv - randomized self-checking bench for alu_operand_stack

module tb_alu_operand_stack;

    localparam int DEPTH = 16;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           push_valid = 1'b0;
    logic           push_ready;
    logic [31:0]    push_data = '0;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [4:0]     op_ctrl = '0;
    logic [1:0]     op_nargs = '0;
    logic           op_discard = 1'b0;
    logic [31:0]    alu_A, alu_B, alu_C;
    logic [4:0]     alu_ctrl;
    logic [31:0]    alu_result;
    logic           done;
    logic [31:0]    done_result;
    logic [SPW-1:0] sp;
    logic [31:0]    tos;
    logic           err_op;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] mq[$];
    bit          merr;

    always #5 clk = ~clk;

    // External ALU: A is top of stack, B second, C third.
    function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] x);
        case (c)
            5'd0:    return b + a;
            5'd1:    return b - a;
            5'd2:    return b * a;
            5'd3:    return b ^ a;
            5'd4:    return (a != 0) ? x : b;
            5'd5:    return b & a;
            5'd6:    return (b == a) ? 32'd1 : 32'd0;
            default: return b | a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_A, alu_B, alu_C);

    alu_operand_stack #(.DEPTH(DEPTH), .ST_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_ctrl(op_ctrl), .op_nargs(op_nargs),
`ifdef OPSTACK_DISCARD_EN
        .op_discard(op_discard),
`endif
        .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .done(done), .done_result(done_result),
        .sp(sp), .tos(tos), .err_op(err_op)
    );

    function automatic logic [31:0] model_tos();
        return (mq.size() == 0) ? 32'd0 : mq[mq.size()-1];
    endfunction

    task automatic model_op(input logic [4:0] c, input logic [1:0] n, input bit disc,
                            output bit legal, output logic [31:0] a, output logic [31:0] b,
                            output logic [31:0] x, output logic [31:0] r);
        legal = (n != 0) && (int'(n) <= mq.size());
        a = 0; b = 0; x = 0; r = 0;
        if (!legal) begin
            merr = 1'b1;
            return;
        end
        if (n >= 1) a = mq.pop_back();
        if (n >= 2) b = mq.pop_back();
        if (n >= 3) x = mq.pop_back();
        r = alu_fn(c, a, b, x);
        if (!disc) mq.push_back(r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push_valid = 1'b0;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        merr = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] v);
        @(negedge clk);
        push_valid = 1'b1;
        push_data = v;
        @(posedge clk);
        #1 push_valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(v);
    endtask

    // Issues one op and returns what the DUT showed in EXEC and PUSH.
    // lat counts negedges after the EXEC sample until done was seen.
    task automatic do_op(input logic [4:0] c, input logic [1:0] n, input bit disc,
                         output logic [31:0] a, output logic [31:0] b, output logic [31:0] x,
                         output bit got, output logic [31:0] res, output int lat);
        @(negedge clk);
        op_ctrl = c;
        op_nargs = n;
        op_discard = disc;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        op_discard = 1'b0;
        @(negedge clk);
        a = alu_A; b = alu_B; x = alu_C;
        got = 1'b0; res = '0; lat = -1;
        for (int i = 0; i < 4; i++) begin
            if (done) begin
                got = 1'b1; res = done_result; lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (sp !== '0) begin n_mis++; $display("FAIL reset_sp: got %0d want 0", sp); end
        n_cmp++; if (tos !== 32'd0) begin n_mis++; $display("FAIL reset_tos: got %0d want 0", tos); end
        n_cmp++; if (done !== 1'b0 || err_op !== 1'b0) begin n_mis++; $display("FAIL reset_flags: got done=%b err=%b want 0/0", done, err_op); end
        n_cmp++; if ({alu_A, alu_B, alu_C, alu_ctrl, done_result} !== '0) begin n_mis++; $display("FAIL reset_regs: got A=%0d B=%0d C=%0d ctrl=%0d res=%0d want all 0", alu_A, alu_B, alu_C, alu_ctrl, done_result); end
        n_cmp++; if (op_ready !== 1'b1 || push_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got op=%b push=%b want 1/1", op_ready, push_ready); end
    endtask

    task automatic test_sub();
        logic [31:0] a, b, x, r, ea, eb, ex, er;
        bit got, legal;
        int lat;
        do_reset();
        do_push(32'd5);
        do_push(32'd3);
        model_op(5'd1, 2'd2, 1'b0, legal, ea, eb, ex, er);
        do_op(5'd1, 2'd2, 1'b0, a, b, x, got, r, lat);
        n_cmp++; if ({a, b, x} !== {32'd3, 32'd5, 32'd0}) begin n_mis++; $display("FAIL sub_operands: got A=%0d B=%0d C=%0d want 3/5/0", a, b, x); end
        n_cmp++; if (got !== 1'b1 || lat !== 1) begin n_mis++; $display("FAIL sub_done_timing: got seen=%b lat=%0d want 1/1", got, lat); end
        n_cmp++; if (r !== 32'd2) begin n_mis++; $display("FAIL sub_result: got %0d want 2", r); end
        @(negedge clk);
        n_cmp++; if (sp !== SPW'(1) || tos !== 32'd2) begin n_mis++; $display("FAIL sub_after: got sp=%0d tos=%0d want 1/2", sp, tos); end
    endtask

    task automatic test_select();
        logic [31:0] a, b, x, r;
        bit got;
        int lat;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            do_push(32'd10);
            do_push(32'd20);
            do_push(k[31:0]);
            do_op(5'd4, 2'd3, 1'b0, a, b, x, got, r, lat);
            n_cmp++; if (got !== 1'b1 || r !== ((k == 0) ? 32'd20 : 32'd10)) begin n_mis++; $display("FAIL select_%0d: got done=%b res=%0d want 1/%0d", k, got, r, (k == 0) ? 20 : 10); end
            @(negedge clk);
            n_cmp++; if (sp !== SPW'(1)) begin n_mis++; $display("FAIL select_sp_%0d: got %0d want 1", k, sp); end
        end
    endtask

    task automatic test_err();
        logic [31:0] a, b, x, r;
        bit got;
        int lat;
        do_reset();
        do_op(5'd0, 2'd2, 1'b0, a, b, x, got, r, lat);
        n_cmp++; if (got !== 1'b0) begin n_mis++; $display("FAIL err_no_done: got done seen=%b want 0", got); end
        n_cmp++; if (err_op !== 1'b1 || sp !== '0 || op_ready !== 1'b1) begin n_mis++; $display("FAIL err_state: got err=%b sp=%0d op_ready=%b want 1/0/1", err_op, sp, op_ready); end
        do_push(32'd7);
        n_cmp++; if (sp !== SPW'(1) || tos !== 32'd7) begin n_mis++; $display("FAIL err_push_after: got sp=%0d tos=%0d want 1/7", sp, tos); end
        do_op(5'd0, 2'd0, 1'b0, a, b, x, got, r, lat);
        n_cmp++; if (got !== 1'b0 || sp !== SPW'(1) || err_op !== 1'b1) begin n_mis++; $display("FAIL err_nargs0: got done=%b sp=%0d err=%b want 0/1/1", got, sp, err_op); end
    endtask

    task automatic test_full();
        logic [31:0] a, b, x, r, ea, eb, ex, er;
        logic [31:0] top;
        bit got, legal;
        int lat;
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push($urandom);
        top = model_tos();
        n_cmp++; if (push_ready !== 1'b0 || sp !== SPW'(DEPTH)) begin n_mis++; $display("FAIL full_state: got push_ready=%b sp=%0d want 0/%0d", push_ready, sp, DEPTH); end
        do_push(32'hDEAD_BEEF);
        n_cmp++; if (sp !== SPW'(DEPTH) || tos !== top) begin n_mis++; $display("FAIL full_ignore: got sp=%0d tos=%h want %0d/%h", sp, tos, DEPTH, top); end
        model_op(5'd0, 2'd2, 1'b0, legal, ea, eb, ex, er);
        do_op(5'd0, 2'd2, 1'b0, a, b, x, got, r, lat);
        n_cmp++; if (got !== 1'b1 || r !== er) begin n_mis++; $display("FAIL full_op_result: got done=%b res=%h want 1/%h", got, r, er); end
        @(negedge clk);
        n_cmp++; if (sp !== SPW'(DEPTH - 1) || tos !== er) begin n_mis++; $display("FAIL full_op_sp: got sp=%0d tos=%h want %0d/%h", sp, tos, DEPTH - 1, er); end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        bit got;
        do_reset();
        do_push(32'd9);
        v = $urandom;
        @(negedge clk);
        push_valid = 1'b1; push_data = v;
        op_valid = 1'b1; op_ctrl = 5'd1; op_nargs = 2'd2;
        #1;
        n_cmp++; if (op_ready !== 1'b0) begin n_mis++; $display("FAIL prio_op_ready: got %b want 0", op_ready); end
        @(posedge clk);
        #1 push_valid = 1'b0;
        n_cmp++; if (sp !== SPW'(2) || tos !== v) begin n_mis++; $display("FAIL prio_push_taken: got sp=%0d tos=%h want 2/%h", sp, tos, v); end
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (alu_A !== v || alu_B !== 32'd9) begin n_mis++; $display("FAIL prio_operands: got A=%h B=%0d want %h/9", alu_A, alu_B, v); end
        @(negedge clk);
        got = done;
        n_cmp++; if (got !== 1'b1 || done_result !== 32'd9 - v) begin n_mis++; $display("FAIL prio_result: got done=%b res=%h want 1/%h", got, done_result, 32'd9 - v); end
        @(negedge clk);
        mq.delete();
        mq.push_back(32'd9 - v);
    endtask

    task automatic test_reset_exec();
        bit seen;
        do_reset();
        do_push(32'd1);
        do_push(32'd2);
        @(negedge clk);
        op_valid = 1'b1; op_ctrl = 5'd0; op_nargs = 2'd2;
        @(posedge clk);
        #1 op_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_mis++; $display("FAIL rst_exec_no_done: got done seen=%b want 0", seen); end
        n_cmp++; if (sp !== '0 || op_ready !== 1'b1 || tos !== 32'd0) begin n_mis++; $display("FAIL rst_exec_state: got sp=%0d op_ready=%b tos=%0d want 0/1/0", sp, op_ready, tos); end
        mq.delete();
        merr = 1'b0;
    endtask

`ifdef OPSTACK_DISCARD_EN
    task automatic test_discard();
        logic [31:0] a, b, x, r;
        bit got;
        int lat;
        do_reset();
        do_push(32'd4);
        do_push(32'd4);
        do_op(5'd6, 2'd2, 1'b1, a, b, x, got, r, lat);
        n_cmp++; if (got !== 1'b1 || r !== 32'd1) begin n_mis++; $display("FAIL discard_result: got done=%b res=%0d want 1/1", got, r); end
        @(negedge clk);
        n_cmp++; if (sp !== '0 || tos !== 32'd0) begin n_mis++; $display("FAIL discard_sp: got sp=%0d tos=%0d want 0/0", sp, tos); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a, b, x, r, ea, eb, ex, er;
        logic [4:0]  c;
        logic [1:0]  n;
        bit got, legal;
        int lat;
        do_reset();
        for (int it = 0; it < 150; it++) begin
            if (($urandom_range(0, 1) == 0) && (mq.size() < DEPTH)) begin
                do_push($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 2)) : $urandom);
            end else begin
                c = 5'($urandom_range(0, 7));
                n = 2'($urandom_range(0, 3));
                model_op(c, n, 1'b0, legal, ea, eb, ex, er);
                do_op(c, n, 1'b0, a, b, x, got, r, lat);
                n_cmp++; if (got !== legal) begin n_mis++; $display("FAIL rnd_done_%0d: got %b want %b", it, got, legal); end
                if (legal) begin
                    n_cmp++; if ({a, b, x, r} !== {ea, eb, ex, er}) begin n_mis++; $display("FAIL rnd_op_%0d: got A=%h B=%h C=%h res=%h want %h/%h/%h/%h", it, a, b, x, r, ea, eb, ex, er); end
                    @(negedge clk);
                end
            end
            n_cmp++; if (sp !== SPW'(mq.size()) || tos !== model_tos() || err_op !== merr) begin n_mis++; $display("FAIL rnd_state_%0d: got sp=%0d tos=%h err=%b want %0d/%h/%b", it, sp, tos, err_op, mq.size(), model_tos(), merr); end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_select();
        test_err();
        test_full();
        test_priority();
        test_reset_exec();
`ifdef OPSTACK_DISCARD_EN
        test_discard();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
